// File: rtl/cordic_iter_var_cnt_pkg.sv
// Shared CORDIC constants: atan(2^-i) table in IEEE-754 single precision,
// X/Y/Z variable encodings and the iteration-count ceiling.
package cordic_pkg;

    localparam int ITER_MAX = 24;

    typedef enum logic [1:0] {
        VAR_X = 2'd0,
        VAR_Y = 2'd1,
        VAR_Z = 2'd2
    } cordic_var_e;

    // Entry i is atan(2^-i) rounded to nearest-even; from i=12 on it equals 2^-i exactly.
    localparam logic [0:ITER_MAX-1][31:0] ATAN_TAB = {
        32'h3F490FDB, 32'h3EED6338, 32'h3E7ADBB0, 32'h3DFEADD5,
        32'h3D7FAADE, 32'h3CFFEAAE, 32'h3C7FFAAB, 32'h3BFFFEAB,
        32'h3B7FFFAB, 32'h3AFFFFEB, 32'h3A7FFFFB, 32'h39FFFFFF,
        32'h39800000, 32'h39000000, 32'h38800000, 32'h38000000,
        32'h37800000, 32'h37000000, 32'h36800000, 32'h36000000,
        32'h35800000, 32'h35000000, 32'h34800000, 32'h34000000
    };

endpackage

// File: rtl/cordic_iter_var_cnt_if.sv
// Control/status bundle between the CORDIC FSM (master) and the counter/LUT stage (slave).
interface cordic_cnt_if #(
    parameter int CW = 4,
    parameter int W  = 32
);
    logic          load_cont_iter;
    logic          enab_cont_iter;
    logic          load_cont_var;
    logic          enab_cont_var;
    logic          enab_dff_LUT;
    logic [CW-1:0] cont_iter;
    logic [1:0]    cont_var;
    logic          max_tick_iter;
    logic          min_tick_iter;
    logic          max_tick_var;
    logic          min_tick_var;
    logic [W-1:0]  lut_atan;
    logic          iter_ovf;

    modport master (
        output load_cont_iter, enab_cont_iter, load_cont_var, enab_cont_var, enab_dff_LUT,
        input  cont_iter, cont_var, max_tick_iter, min_tick_iter,
               max_tick_var, min_tick_var, lut_atan, iter_ovf
    );

    modport slave (
        input  load_cont_iter, enab_cont_iter, load_cont_var, enab_cont_var, enab_dff_LUT,
        output cont_iter, cont_var, max_tick_iter, min_tick_iter,
               max_tick_var, min_tick_var, lut_atan, iter_ovf
    );
endinterface

// File: rtl/cordic_iter_var_cnt_mod_cnt.sv
// Generic modulo-MOD counter with synchronous clear, enable, and max/min ticks.
// With SAT set, an enable at MOD-1 holds the count instead of wrapping.
module cordic_mod_cnt #(
    parameter int MOD = 3,
    parameter int W   = 2,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         enab,
    output logic [W-1:0] count,
    output logic         max_tick,
    output logic         min_tick
);
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enab) begin
            if (count == LAST) begin
                count <= SAT ? LAST : '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign max_tick = (count == LAST);
    assign min_tick = (count == '0);
endmodule

// File: rtl/cordic_iter_var_cnt.sv
// Iteration/variable counters and registered atan LUT feeding the CORDIC FSM.
// Define CORDIC_ITER_SAT_EN to saturate the iteration counter and flag overflow.
module cordic_iter_var_cnt
    import cordic_pkg::*;
#(
    parameter int ITER = 16,
    parameter int W    = 32
) (
    input logic         clk,
    input logic         reset,
    cordic_cnt_if.slave bus
);
    localparam int CW      = $clog2(ITER);
    localparam int VAR_MOD = int'(VAR_Z) + 1;

`ifdef CORDIC_ITER_SAT_EN
    localparam bit ITER_SAT = 1'b1;
`else
    localparam bit ITER_SAT = 1'b0;
`endif

    logic [W-1:0] lut_q;

    cordic_mod_cnt #(
        .MOD (ITER),
        .W   (CW),
        .SAT (ITER_SAT)
    ) iter_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (bus.load_cont_iter),
        .enab     (bus.enab_cont_iter),
        .count    (bus.cont_iter),
        .max_tick (bus.max_tick_iter),
        .min_tick (bus.min_tick_iter)
    );

    cordic_mod_cnt #(
        .MOD (VAR_MOD),
        .W   (2),
        .SAT (1'b0)
    ) var_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (bus.load_cont_var),
        .enab     (bus.enab_cont_var),
        .count    (bus.cont_var),
        .max_tick (bus.max_tick_var),
        .min_tick (bus.min_tick_var)
    );

    // Indexed by the registered count, so a same-cycle increment still captures the current entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lut_q <= '0;
        end else if (bus.enab_dff_LUT) begin
            lut_q <= W'(ATAN_TAB[bus.cont_iter]);
        end
    end

    assign bus.lut_atan = lut_q;

`ifdef CORDIC_ITER_SAT_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if (bus.load_cont_iter) begin
            ovf_q <= 1'b0;
        end else if (bus.enab_cont_iter && bus.max_tick_iter) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.iter_ovf = ovf_q;
`else
    assign bus.iter_ovf = 1'b0;
`endif
endmodule

// File: doc/cordic_iter_var_cnt.md
# cordic_iter_var_cnt

Counter and arctangent look-up stage that sits directly upstream of the CORDIC control FSM. It holds the iteration counter and the X/Y/Z variable counter, and returns the count values and max/min ticks to the FSM. It also provides the registered single-precision atan(2^-i) constant for the Z-path adder. The FSM's load/enable outputs drive this block, and its tick outputs close the FSM's loop.

## Interface
- ITER, 16, number of CORDIC iterations; legal range 2..24
- CW, $clog2(ITER), iteration counter width (derived, not overridden)
- W, 32, LUT word width (IEEE-754 single)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- load_cont_iter  in  1  synchronous clear of iteration counter
- enab_cont_iter  in  1  increment iteration counter
- load_cont_var  in  1  synchronous clear of variable counter
- enab_cont_var  in  1  increment variable counter
- enab_dff_LUT  in  1  capture LUT entry for current cont_iter
- cont_iter  out  CW  current iteration index (also the shift amount)
- cont_var  out  2  current variable: 0=X, 1=Y, 2=Z
- max_tick_iter  out  1  cont_iter == ITER-1
- min_tick_iter  out  1  cont_iter == 0
- max_tick_var  out  1  cont_var == 2
- min_tick_var  out  1  cont_var == 0
- lut_atan  out  W  registered atan(2^-cont_iter)
- iter_ovf  out  1  sticky overflow flag (see Configuration)

## Operation
- Reset values: cont_iter=0, cont_var=0, lut_atan=0, iter_ovf=0. Ticks follow the counts: min ticks=1, max ticks=0.
- Iteration counter:
  - load has priority over enab.
  - enab with count < ITER-1 increments the count.
  - enab at ITER-1 wraps the count to 0.
- Variable counter:
  - Counts 0→1→2→0. The value 3 is never produced.
  - load has priority over enab.
- Ticks are combinational decodes of the registered counts. They have no dependence on the enable inputs.
- LUT:
  - Constant table ATAN_TAB[0..23], selected by cont_iter.
  - enab_dff_LUT loads lut_atan. Otherwise lut_atan holds.
  - Required entries: [0]=0x3F490FDB, [1]=0x3EED6338, [2]=0x3E7ADBB0, [3]=0x3DFEADD5. Entries [i]=atan(2^-i), rounded to nearest-even.
- Simultaneous enab_cont_iter and enab_dff_LUT: the LUT captures the entry for the pre-increment count.
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronous). Deassertion is synchronised by the surrounding design.

## Timing
- Counters update on the clock edge where load/enab is sampled high. The new count and ticks are visible in that same cycle after the edge.
- lut_atan latency: 1 cycle from enab_dff_LUT.
- One enab pulse equals exactly one step. A held enab steps once per cycle.
- No handshake. The FSM guarantees that enab_cont_var and enab_cont_iter are not asserted in the same cycle; if they are, both counters step independently.

## Configuration
- CORDIC_ITER_SAT_EN undefined (default):
  - The iteration counter wraps ITER-1→0.
  - iter_ovf is tied to 0.
- CORDIC_ITER_SAT_EN defined:
  - enab_cont_iter at ITER-1 holds the count at ITER-1 and sets iter_ovf.
  - iter_ovf is cleared only by load_cont_iter or reset.
  - load_cont_iter and an overflowing enab in the same cycle: the load wins, and iter_ovf is cleared.

## Structure
- Shared package cordic_pkg holds:
  - ATAN_TAB (24×32 localparam array)
  - variable encodings VAR_X=2'd0, VAR_Y=2'd1, VAR_Z=2'd2
  - the ITER_MAX=24 limit
- One sub-module, cordic_mod_cnt (generic load/enable/wrap counter with max/min ticks). It is instantiated twice: modulus ITER and modulus 3.
- The LUT register stays in the top level.

## Test plan
- Reset: drive reset=0 for 3 cycles, then 1 → cont_iter=0, cont_var=0, min ticks=1, max ticks=0, lut_atan=0, iter_ovf=0.
- Iteration sweep, ITER=16: pulse load, then 16 enab → max_tick_iter high only at count 15. The next enab returns the count to 0 with min_tick_iter=1 (default build).
- Variable sweep: 4 enab_cont_var → sequence 1,2,0,1. max_tick_var is high only at 2.
- LUT: set cont_iter=0..3 and pulse enab_dff_LUT each time → lut_atan = 0x3F490FDB, 0x3EED6338, 0x3E7ADBB0, 0x3DFEADD5, each one cycle after its enable.
- Priority: assert load_cont_iter and enab_cont_iter together at count 7 → count=0.
- CORDIC_ITER_SAT_EN build: 17 enab from 0 → count stays 15 and iter_ovf=1. A subsequent load → count=0 and iter_ovf=0.
